// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb arming controller.
package bomb_pkg;

    localparam int CODE_W  = 4;
    localparam int TIMER_W = 4;
    localparam int TRIES_W = 2;

    localparam logic [CODE_W-1:0] DEFAULT_SECRET_CODE = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_COUNTING  = 3'd2,
        ST_DEFUSED   = 3'd3,
        ST_EXPLODED  = 3'd4
    } state_t;

    function automatic logic [TRIES_W-1:0] sat_dec(input logic [TRIES_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when sig_i is high and was low last cycle.
module edge_pulse (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;

    // History is forced high in reset so a button held through reset never pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/bomb_arm_ctrl.sv
// Arming/defuse sequencer driving an external countdown timer.
// Optional macro LOCKOUT_EN: running out of attempts explodes the bomb.
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_IDLE     | waiting for arm, timer held
// ST_ARMING   | one-cycle timer reload, attempts refilled
// ST_COUNTING | timer running, codes accepted
// ST_DEFUSED  | correct code entered, remaining time frozen
// ST_EXPLODED | timer expired (or locked out); only Reset leaves
module bomb_arm_ctrl
    import bomb_pkg::*;
#(
    parameter logic [CODE_W-1:0]  SECRET_CODE = DEFAULT_SECRET_CODE,
    parameter logic [TRIES_W-1:0] MAX_TRIES   = 2'd3,
    parameter logic [TIMER_W-1:0] WARN_LEVEL  = 4'd4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               arm_btn,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               code_enter,
    input  logic [TIMER_W-1:0] Counter_Out,
    input  logic               blow_up,
    output logic               start,
    output logic               stop,
    output logic               timer_reset,
    output logic               defused,
    output logic               exploded,
    output logic               warn,
    output logic [TRIES_W-1:0] tries_left,
    output logic [TIMER_W-1:0] remaining
);

    state_t               state_q, state_d;
    logic [TRIES_W-1:0]   tries_q, tries_d;
    logic [TIMER_W-1:0]   remaining_q, remaining_d;
    logic                 arm_pulse, enter_pulse;

    edge_pulse u_arm_edge (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .sig_i   (arm_btn),
        .pulse_o (arm_pulse)
    );

    edge_pulse u_enter_edge (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .sig_i   (code_enter),
        .pulse_o (enter_pulse)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            tries_q     <= MAX_TRIES;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        remaining_d = remaining_q;

        unique case (state_q)
            ST_IDLE, ST_DEFUSED: begin
                if (arm_pulse && !blow_up) begin
                    state_d = ST_ARMING;
                    tries_d = MAX_TRIES;
                end
            end
            ST_ARMING: begin
                state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
                // Expiry wins over a same-cycle code entry.
                if (blow_up) begin
                    state_d = ST_EXPLODED;
                end else if (enter_pulse) begin
                    if (code_in == SECRET_CODE) begin
                        state_d     = ST_DEFUSED;
                        remaining_d = Counter_Out;
                    end else begin
                        tries_d = sat_dec(tries_q);
`ifdef LOCKOUT_EN
                        if (tries_q <= 2'd1) begin
                            state_d = ST_EXPLODED;
                        end
`endif
                    end
                end
            end
            ST_EXPLODED: begin
                state_d = ST_EXPLODED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start       = (state_q == ST_COUNTING);
    assign stop        = (state_q != ST_COUNTING);
    assign timer_reset = (state_q == ST_ARMING);
    assign defused     = (state_q == ST_DEFUSED);
    assign exploded    = (state_q == ST_EXPLODED);
    assign warn        = (state_q == ST_COUNTING) && (Counter_Out <= WARN_LEVEL);
    assign tries_left  = tries_q;
    assign remaining   = remaining_q;

endmodule
